lsu_ctrl: RTL and testbench
===========================

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter MAX_WAIT, default 16, SHALL set the cycle budget for one bus transaction (REQ plus WAIT states) before timeout; legal range 2..255.
REQ-002 clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_ni  input  1  SHALL be an asynchronous, active-low reset.
REQ-004 lsu_req_i  input  1  SHALL indicate the pipeline requests a load/store; sampled only in IDLE.
REQ-005 lsu_we_i  input  1  SHALL select store (1) or load (0).
REQ-006 lsu_addr_i, lsu_wdata_i  input  32 each  SHALL carry the byte address and unaligned store data.
REQ-007 lsu_size_i  input  mem_size_e; lsu_signed_i  input  1  SHALL give access size and load sign-extension.
REQ-008 lsu_busy_o  output  1  SHALL be high whenever state is not IDLE.
REQ-009 lsu_done_o  output  1  SHALL be a one-cycle completion pulse.
REQ-010 lsu_rdata_o  output  32  SHALL hold the aligned, extended load result.
REQ-011 lsu_err_misaligned_o, lsu_err_timeout_o  output  1 each  SHALL qualify lsu_done_o with the error cause.
REQ-012 lsu_err_addr_o  output  32  SHALL hold the faulting byte address.
REQ-013 data_req_o  output  1; data_gnt_i  input  1  SHALL form the bus address-phase handshake.
REQ-014 data_addr_o  output  32; data_we_o  output  1; data_be_o  output  4; data_wdata_o  output  32  SHALL be the bus command.
REQ-015 data_rvalid_i  input  1; data_rdata_i  input  32  SHALL form the bus response phase.

Function
REQ-016 States SHALL be IDLE, REQ, WAIT; all outputs SHALL be registered.
REQ-017 Misaligned: HALF with addr[0]=1, WORD with addr[1:0]!=0; BYTE never misaligned.
REQ-018 IDLE with lsu_req_i=1 and misaligned SHALL stay IDLE, issue no bus request, and next cycle pulse lsu_done_o with lsu_err_misaligned_o=1 and lsu_err_addr_o=lsu_addr_i.
REQ-019 IDLE with lsu_req_i=1 and aligned SHALL latch the command, go to REQ, and assert data_req_o from the next cycle.
REQ-020 Latched bus command: data_addr_o = {addr[31:2],2'b00}; data_be_o = 0001<<off (BYTE), 0011/1100 by addr[1] (HALF), 1111 (WORD); data_wdata_o = store data replicated into the enabled lanes; data_be_o = 1111 for loads.
REQ-021 In REQ, data_req_o and all command outputs SHALL stay stable until data_gnt_i=1; on that cycle go to WAIT and deassert data_req_o the next cycle.
REQ-022 data_rvalid_i SHALL be ignored outside WAIT, including stray responses after a timeout.
REQ-023 In WAIT, data_rvalid_i=1 SHALL return to IDLE and pulse lsu_done_o next cycle; for loads lsu_rdata_o = byte/half lane selected by latched addr[1:0], zero- or sign-extended per lsu_signed_i; WORD passes through; stores SHALL leave lsu_rdata_o unchanged.
REQ-024 A wait counter SHALL clear on entering REQ and increment each cycle in REQ/WAIT; if it reaches MAX_WAIT-1 without the awaited gnt/rvalid, go IDLE, drop data_req_o, and pulse lsu_done_o with lsu_err_timeout_o=1 and lsu_err_addr_o = latched address.
REQ-025 If gnt or rvalid arrives in the same cycle the counter hits MAX_WAIT-1, the handshake SHALL win over timeout.
REQ-026 Error flags SHALL be high only in the lsu_done_o cycle; both SHALL never be high together.
REQ-027 lsu_req_i SHALL be accepted in the same IDLE cycle as a lsu_done_o pulse.
REQ-028 Minimum latency: accept cycle 0, data_req_o cycle 1 with gnt, rvalid cycle 2, lsu_done_o cycle 3.

Reset
REQ-029 rst_ni low SHALL immediately force IDLE, counter 0, and all outputs 0, including mid-transaction; no pending response is tracked after reset.

Verification
REQ-030 LB signed, addr 0x1003, rdata 0x80_00_00_00, gnt cycle 1, rvalid cycle 2 -> data_addr_o 0x1000, data_be_o 1111, lsu_done_o cycle 3, lsu_rdata_o 0xFFFFFF80.
REQ-031 SH addr 0x2002, wdata 0x0000BEEF, gnt delayed 3 cycles -> data_req_o held 4 cycles, data_be_o 1100, data_wdata_o 0xBEEFBEEF stable, done after rvalid.
REQ-032 LW addr 0x3001 -> no data_req_o, lsu_done_o next cycle, err_misaligned=1, err_addr 0x3001.
REQ-033 MAX_WAIT=4, LHU addr 0x4000, no gnt -> data_req_o drops, done with err_timeout=1, err_addr 0x4000; later stray rvalid ignored.
REQ-034 rst_ni pulled low in WAIT -> outputs 0 and state IDLE without a clock edge; next load completes normally.
REQ-035 Back-to-back: new lsu_req_i in the lsu_done_o cycle -> data_req_o asserted next cycle.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit and its pipeline/bus interface.
package lsu_pkg;
    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } mem_size_e;
endpackage

// File: rtl/lsu_ctrl_if.sv
// Pipeline request side and data-bus side of the LSU, bundled as one interface.
// slave = the LSU controller's view, master = the pipeline/bus environment's view.
interface lsu_ctrl_if;
    import lsu_pkg::*;

    logic            lsu_req_i;
    logic            lsu_we_i;
    logic [31:0]     lsu_addr_i;
    logic [31:0]     lsu_wdata_i;
    mem_size_e       lsu_size_i;
    logic            lsu_signed_i;
    logic            lsu_busy_o;
    logic            lsu_done_o;
    logic [31:0]     lsu_rdata_o;
    logic            lsu_err_misaligned_o;
    logic            lsu_err_timeout_o;
    logic [31:0]     lsu_err_addr_o;

    logic            data_req_o;
    logic            data_gnt_i;
    logic [31:0]     data_addr_o;
    logic            data_we_o;
    logic [3:0]      data_be_o;
    logic [31:0]     data_wdata_o;
    logic            data_rvalid_i;
    logic [31:0]     data_rdata_i;

    modport slave (
        input  lsu_req_i, lsu_we_i, lsu_addr_i, lsu_wdata_i, lsu_size_i, lsu_signed_i,
        input  data_gnt_i, data_rvalid_i, data_rdata_i,
        output lsu_busy_o, lsu_done_o, lsu_rdata_o, lsu_err_misaligned_o,
        output lsu_err_timeout_o, lsu_err_addr_o,
        output data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o
    );

    modport master (
        output lsu_req_i, lsu_we_i, lsu_addr_i, lsu_wdata_i, lsu_size_i, lsu_signed_i,
        output data_gnt_i, data_rvalid_i, data_rdata_i,
        input  lsu_busy_o, lsu_done_o, lsu_rdata_o, lsu_err_misaligned_o,
        input  lsu_err_timeout_o, lsu_err_addr_o,
        input  data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o
    );
endinterface

// File: rtl/lsu_ctrl.sv
// Single-outstanding load/store controller: aligns and issues one bus access, extracts load data.
// Latency 3 cycles min (accept, gnt, rvalid, done); bus stall bounded by MAX_WAIT, then timeout error.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    lsu_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_e;

    localparam logic [7:0] CNT_LAST = 8'(MAX_WAIT - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    mem_size_e   size_q, size_d;
    logic        signed_q, signed_d;
    logic        we_q, we_d;

    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_mis_q, err_mis_d;
    logic        err_to_q, err_to_d;
    logic [31:0] err_addr_q, err_addr_d;
    logic        data_req_q, data_req_d;
    logic [31:0] data_addr_q, data_addr_d;
    logic        data_we_q, data_we_d;
    logic [3:0]  data_be_q, data_be_d;
    logic [31:0] data_wdata_q, data_wdata_d;

    logic        misaligned;
    logic [3:0]  cmd_be;
    logic [31:0] cmd_wdata;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_val;
    logic        timeout_hit;

    assign timeout_hit = (cnt_q >= CNT_LAST);

    // Alignment check and lane steering for the incoming command.
    always_comb begin
        misaligned = 1'b0;
        cmd_be     = 4'b1111;
        cmd_wdata  = bus.lsu_wdata_i;
        case (bus.lsu_size_i)
            MEM_BYTE: begin
                cmd_be    = 4'b0001 << bus.lsu_addr_i[1:0];
                cmd_wdata = {4{bus.lsu_wdata_i[7:0]}};
            end
            MEM_HALF: begin
                misaligned = bus.lsu_addr_i[0];
                cmd_be     = bus.lsu_addr_i[1] ? 4'b1100 : 4'b0011;
                cmd_wdata  = {2{bus.lsu_wdata_i[15:0]}};
            end
            default: begin
                misaligned = |bus.lsu_addr_i[1:0];
            end
        endcase
        if (!bus.lsu_we_i) begin
            cmd_be = 4'b1111;
        end
    end

    always_comb begin
        lane_b = bus.data_rdata_i[7:0];
        case (addr_q[1:0])
            2'd1:    lane_b = bus.data_rdata_i[15:8];
            2'd2:    lane_b = bus.data_rdata_i[23:16];
            2'd3:    lane_b = bus.data_rdata_i[31:24];
            default: lane_b = bus.data_rdata_i[7:0];
        endcase
        lane_h = addr_q[1] ? bus.data_rdata_i[31:16] : bus.data_rdata_i[15:0];
        case (size_q)
            MEM_BYTE: load_val = {{24{signed_q & lane_b[7]}}, lane_b};
            MEM_HALF: load_val = {{16{signed_q & lane_h[15]}}, lane_h};
            default:  load_val = bus.data_rdata_i;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        size_d       = size_q;
        signed_d     = signed_q;
        we_d         = we_q;
        done_d       = 1'b0;
        err_mis_d    = 1'b0;
        err_to_d     = 1'b0;
        rdata_d      = rdata_q;
        err_addr_d   = err_addr_q;
        data_req_d   = data_req_q;
        data_addr_d  = data_addr_q;
        data_we_d    = data_we_q;
        data_be_d    = data_be_q;
        data_wdata_d = data_wdata_q;

        case (state_q)
            S_IDLE: begin
                if (bus.lsu_req_i) begin
                    if (misaligned) begin
                        done_d     = 1'b1;
                        err_mis_d  = 1'b1;
                        err_addr_d = bus.lsu_addr_i;
                    end else begin
                        state_d      = S_REQ;
                        cnt_d        = 8'd0;
                        addr_d       = bus.lsu_addr_i;
                        size_d       = bus.lsu_size_i;
                        signed_d     = bus.lsu_signed_i;
                        we_d         = bus.lsu_we_i;
                        data_req_d   = 1'b1;
                        data_addr_d  = {bus.lsu_addr_i[31:2], 2'b00};
                        data_we_d    = bus.lsu_we_i;
                        data_be_d    = cmd_be;
                        data_wdata_d = cmd_wdata;
                    end
                end
            end
            S_REQ: begin
                // A grant on the last budgeted cycle still counts.
                if (bus.data_gnt_i) begin
                    state_d    = S_WAIT;
                    data_req_d = 1'b0;
                    cnt_d      = cnt_q + 8'd1;
                end else if (timeout_hit) begin
                    state_d    = S_IDLE;
                    data_req_d = 1'b0;
                    done_d     = 1'b1;
                    err_to_d   = 1'b1;
                    err_addr_d = addr_q;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_WAIT: begin
                if (bus.data_rvalid_i) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    if (!we_q) begin
                        rdata_d = load_val;
                    end
                end else if (timeout_hit) begin
                    state_d    = S_IDLE;
                    done_d     = 1'b1;
                    err_to_d   = 1'b1;
                    err_addr_d = addr_q;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d    = S_IDLE;
                data_req_d = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            cnt_q        <= 8'd0;
            addr_q       <= 32'd0;
            size_q       <= MEM_BYTE;
            signed_q     <= 1'b0;
            we_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rdata_q      <= 32'd0;
            err_mis_q    <= 1'b0;
            err_to_q     <= 1'b0;
            err_addr_q   <= 32'd0;
            data_req_q   <= 1'b0;
            data_addr_q  <= 32'd0;
            data_we_q    <= 1'b0;
            data_be_q    <= 4'd0;
            data_wdata_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            we_q         <= we_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            rdata_q      <= rdata_d;
            err_mis_q    <= err_mis_d;
            err_to_q     <= err_to_d;
            err_addr_q   <= err_addr_d;
            data_req_q   <= data_req_d;
            data_addr_q  <= data_addr_d;
            data_we_q    <= data_we_d;
            data_be_q    <= data_be_d;
            data_wdata_q <= data_wdata_d;
        end
    end

    assign bus.lsu_busy_o           = busy_q;
    assign bus.lsu_done_o           = done_q;
    assign bus.lsu_rdata_o          = rdata_q;
    assign bus.lsu_err_misaligned_o = err_mis_q;
    assign bus.lsu_err_timeout_o    = err_to_q;
    assign bus.lsu_err_addr_o       = err_addr_q;
    assign bus.data_req_o           = data_req_q;
    assign bus.data_addr_o          = data_addr_q;
    assign bus.data_we_o            = data_we_q;
    assign bus.data_be_o            = data_be_q;
    assign bus.data_wdata_o         = data_wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: default-budget instance plus a MAX_WAIT=4 instance for timeout cases.
// Expected completions are queued at issue and popped on each lsu_done_o pulse.
module tb_lsu_ctrl;
    import lsu_pkg::*;

    logic clk_i = 1'b0;
    logic rst_ni;
    always #5 clk_i = ~clk_i;

    lsu_ctrl_if ifa();
    lsu_ctrl_if ifb();

    lsu_ctrl #(.MAX_WAIT(16)) u_dut  (.clk_i(clk_i), .rst_ni(rst_ni), .bus(ifa));
    lsu_ctrl #(.MAX_WAIT(4))  u_dut4 (.clk_i(clk_i), .rst_ni(rst_ni), .bus(ifb));

    typedef struct packed {
        logic        mis;
        logic        to;
        logic [31:0] eaddr;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sbq[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] last_rdata_a = 32'd0;
    logic [31:0] last_rdata_b = 32'd0;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        ifa.lsu_req_i = 0; ifa.lsu_we_i = 0; ifa.lsu_addr_i = 0; ifa.lsu_wdata_i = 0;
        ifa.lsu_size_i = MEM_BYTE; ifa.lsu_signed_i = 0;
        ifa.data_gnt_i = 0; ifa.data_rvalid_i = 0; ifa.data_rdata_i = 0;
        ifb.lsu_req_i = 0; ifb.lsu_we_i = 0; ifb.lsu_addr_i = 0; ifb.lsu_wdata_i = 0;
        ifb.lsu_size_i = MEM_BYTE; ifb.lsu_signed_i = 0;
        ifb.data_gnt_i = 0; ifb.data_rvalid_i = 0; ifb.data_rdata_i = 0;
    endtask

    task automatic issue_a(input logic we, input mem_size_e sz, input logic sg,
                           input logic [31:0] ad, input logic [31:0] wd);
        ifa.lsu_req_i = 1'b1; ifa.lsu_we_i = we; ifa.lsu_size_i = sz;
        ifa.lsu_signed_i = sg; ifa.lsu_addr_i = ad; ifa.lsu_wdata_i = wd;
    endtask

    task automatic test_reset();
        logic [140:0] va, vb;
        va = {ifa.lsu_busy_o, ifa.lsu_done_o, ifa.lsu_err_misaligned_o, ifa.lsu_err_timeout_o,
              ifa.data_req_o, ifa.data_we_o, ifa.data_be_o, ifa.data_addr_o, ifa.data_wdata_o,
              ifa.lsu_rdata_o, ifa.lsu_err_addr_o};
        vb = {ifb.lsu_busy_o, ifb.lsu_done_o, ifb.lsu_err_misaligned_o, ifb.lsu_err_timeout_o,
              ifb.data_req_o, ifb.data_we_o, ifb.data_be_o, ifb.data_addr_o, ifb.data_wdata_o,
              ifb.lsu_rdata_o, ifb.lsu_err_addr_o};
        checks++;
        if (va !== '0) begin failures++; $display("FAIL reset_outputs_a got=%h exp=0", va); end
        checks++;
        if (vb !== '0) begin failures++; $display("FAIL reset_outputs_b got=%h exp=0", vb); end
    endtask

    task automatic test_lb_signed();
        exp_t e;
        issue_a(1'b0, MEM_BYTE, 1'b1, 32'h0000_1003, 32'd0);
        sbq.push_back({1'b0, 1'b0, 32'd0, 32'hFFFF_FF80});
        tick(); ifa.lsu_req_i = 1'b0;
        checks++;
        if ({ifa.data_req_o, ifa.lsu_busy_o, ifa.data_we_o, ifa.data_be_o, ifa.data_addr_o} !==
            {1'b1, 1'b1, 1'b0, 4'hF, 32'h0000_1000}) begin
            failures++;
            $display("FAIL lb_cmd got=%h exp=%h",
                {ifa.data_req_o, ifa.lsu_busy_o, ifa.data_we_o, ifa.data_be_o, ifa.data_addr_o},
                {1'b1, 1'b1, 1'b0, 4'hF, 32'h0000_1000});
        end
        ifa.data_gnt_i = 1'b1;
        tick(); ifa.data_gnt_i = 1'b0;
        checks++;
        if ({ifa.data_req_o, ifa.lsu_busy_o, ifa.lsu_done_o} !== 3'b010) begin
            failures++; $display("FAIL lb_wait got=%b exp=010", {ifa.data_req_o, ifa.lsu_busy_o, ifa.lsu_done_o});
        end
        ifa.data_rvalid_i = 1'b1; ifa.data_rdata_i = 32'h8000_0000;
        tick(); ifa.data_rvalid_i = 1'b0;
        checks++;
        if ({ifa.lsu_done_o, ifa.lsu_busy_o} !== 2'b10) begin
            failures++; $display("FAIL lb_done_cycle3 got=%b exp=10", {ifa.lsu_done_o, ifa.lsu_busy_o});
        end
        e = sbq.pop_front();
        checks++;
        if ({ifa.lsu_err_misaligned_o, ifa.lsu_err_timeout_o, ifa.lsu_rdata_o} !== {e.mis, e.to, e.rdata}) begin
            failures++;
            $display("FAIL lb_result got=%h exp=%h",
                {ifa.lsu_err_misaligned_o, ifa.lsu_err_timeout_o, ifa.lsu_rdata_o}, {e.mis, e.to, e.rdata});
        end
        last_rdata_a = e.rdata;
        tick();
        checks++;
        if (ifa.lsu_done_o !== 1'b0) begin failures++; $display("FAIL lb_done_pulse got=1 exp=0"); end
    endtask

    task automatic test_sh_delayed_gnt();
        exp_t e;
        issue_a(1'b1, MEM_HALF, 1'b0, 32'h0000_2002, 32'h0000_BEEF);
        sbq.push_back({1'b0, 1'b0, 32'd0, last_rdata_a});
        tick(); ifa.lsu_req_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if ({ifa.data_req_o, ifa.data_we_o, ifa.data_be_o, ifa.data_addr_o, ifa.data_wdata_o} !==
                {1'b1, 1'b1, 4'b1100, 32'h0000_2000, 32'hBEEF_BEEF}) begin
                failures++;
                $display("FAIL sh_cmd_hold c=%0d got=%h exp=%h", c,
                    {ifa.data_req_o, ifa.data_we_o, ifa.data_be_o, ifa.data_addr_o, ifa.data_wdata_o},
                    {1'b1, 1'b1, 4'b1100, 32'h0000_2000, 32'hBEEF_BEEF});
            end
            if (c == 3) ifa.data_gnt_i = 1'b1;
            tick();
        end
        ifa.data_gnt_i = 1'b0;
        checks++;
        if (ifa.data_req_o !== 1'b0) begin failures++; $display("FAIL sh_req_drop got=1 exp=0"); end
        tick();
        ifa.data_rvalid_i = 1'b1; ifa.data_rdata_i = 32'h1234_5678;
        tick(); ifa.data_rvalid_i = 1'b0;
        for (int i = 0; i < 8 && ifa.lsu_done_o !== 1'b1; i++) tick();
        checks++;
        if (ifa.lsu_done_o !== 1'b1) begin
            failures++; $display("FAIL sh_done_timeout got=%b exp=1", ifa.lsu_done_o);
        end else begin
            e = sbq.pop_front();
            checks++;
            if ({ifa.lsu_err_misaligned_o, ifa.lsu_err_timeout_o, ifa.lsu_rdata_o} !== {e.mis, e.to, e.rdata}) begin
                failures++;
                $display("FAIL sh_result got=%h exp=%h",
                    {ifa.lsu_err_misaligned_o, ifa.lsu_err_timeout_o, ifa.lsu_rdata_o}, {e.mis, e.to, e.rdata});
            end
        end
        tick();
    endtask

    task automatic test_misaligned();
        exp_t        e;
        mem_size_e   szs[5] = '{MEM_WORD, MEM_HALF, MEM_HALF, MEM_BYTE, MEM_WORD};
        logic [31:0] ads[5] = '{32'h3001, 32'h5001, 32'h5002, 32'h5003, 32'h5002};
        logic        mis[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [31:0] rds[5] = '{32'd0, 32'd0, 32'h0000_A1B2, 32'h0000_00A1, 32'd0};
        for (int i = 0; i < 5; i++) begin
            issue_a(1'b0, szs[i], 1'b0, ads[i], 32'd0);
            sbq.push_back({mis[i], 1'b0, ads[i], mis[i] ? last_rdata_a : rds[i]});
            tick(); ifa.lsu_req_i = 1'b0;
            if (!mis[i]) begin
                checks++;
                if (ifa.data_req_o !== 1'b1) begin failures++; $display("FAIL align_req i=%0d got=0 exp=1", i); end
                ifa.data_gnt_i = 1'b1;
                tick(); ifa.data_gnt_i = 1'b0;
                ifa.data_rvalid_i = 1'b1; ifa.data_rdata_i = 32'hA1B2_C3D4;
                tick(); ifa.data_rvalid_i = 1'b0;
            end else begin
                checks++;
                if ({ifa.data_req_o, ifa.lsu_busy_o} !== 2'b00) begin
                    failures++; $display("FAIL mis_no_req i=%0d got=%b exp=00", i, {ifa.data_req_o, ifa.lsu_busy_o});
                end
            end
            e = sbq.pop_front();
            checks++;
            if ({ifa.lsu_done_o, ifa.lsu_err_misaligned_o, ifa.lsu_err_timeout_o, ifa.lsu_rdata_o} !==
                {1'b1, e.mis, e.to, e.rdata} || (e.mis && ifa.lsu_err_addr_o !== e.eaddr)) begin
                failures++;
                $display("FAIL mis_result i=%0d got=%h/%h exp=%h/%h", i,
                    {ifa.lsu_done_o, ifa.lsu_err_misaligned_o, ifa.lsu_err_timeout_o, ifa.lsu_rdata_o},
                    ifa.lsu_err_addr_o, {1'b1, e.mis, e.to, e.rdata}, e.eaddr);
            end
            last_rdata_a = e.rdata;
            tick();
            checks++;
            if ({ifa.lsu_done_o, ifa.lsu_err_misaligned_o, ifa.lsu_err_timeout_o} !== 3'b000) begin
                failures++;
                $display("FAIL err_flags_clear i=%0d got=%b exp=000", i,
                    {ifa.lsu_done_o, ifa.lsu_err_misaligned_o, ifa.lsu_err_timeout_o});
            end
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        ifb.lsu_req_i = 1'b1; ifb.lsu_we_i = 1'b0; ifb.lsu_size_i = MEM_HALF;
        ifb.lsu_signed_i = 1'b0; ifb.lsu_addr_i = 32'h0000_4000;
        sbq.push_back({1'b0, 1'b1, 32'h0000_4000, last_rdata_b});
        tick(); ifb.lsu_req_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if ({ifb.data_req_o, ifb.lsu_done_o} !== 2'b10) begin
                failures++; $display("FAIL to_req_held c=%0d got=%b exp=10", c, {ifb.data_req_o, ifb.lsu_done_o});
            end
            tick();
        end
        e = sbq.pop_front();
        checks++;
        if ({ifb.data_req_o, ifb.lsu_busy_o, ifb.lsu_done_o, ifb.lsu_err_misaligned_o, ifb.lsu_err_timeout_o,
             ifb.lsu_err_addr_o, ifb.lsu_rdata_o} !== {3'b001, e.mis, e.to, e.eaddr, e.rdata}) begin
            failures++;
            $display("FAIL to_result got=%h exp=%h",
                {ifb.data_req_o, ifb.lsu_busy_o, ifb.lsu_done_o, ifb.lsu_err_misaligned_o, ifb.lsu_err_timeout_o,
                 ifb.lsu_err_addr_o, ifb.lsu_rdata_o}, {3'b001, e.mis, e.to, e.eaddr, e.rdata});
        end
        tick();
        ifb.data_rvalid_i = 1'b1; ifb.data_rdata_i = 32'hDEAD_BEEF;
        tick(); ifb.data_rvalid_i = 1'b0;
        checks++;
        if ({ifb.lsu_done_o, ifb.lsu_busy_o, ifb.data_req_o, ifb.lsu_rdata_o} !== {3'b000, last_rdata_b}) begin
            failures++;
            $display("FAIL to_stray_rvalid got=%h exp=%h",
                {ifb.lsu_done_o, ifb.lsu_busy_o, ifb.data_req_o, ifb.lsu_rdata_o}, {3'b000, last_rdata_b});
        end
    endtask

    task automatic test_gnt_at_limit();
        exp_t e;
        ifb.lsu_req_i = 1'b1; ifb.lsu_we_i = 1'b0; ifb.lsu_size_i = MEM_WORD;
        ifb.lsu_signed_i = 1'b0; ifb.lsu_addr_i = 32'h0000_4100;
        sbq.push_back({1'b0, 1'b0, 32'd0, 32'hCAFE_F00D});
        tick(); ifb.lsu_req_i = 1'b0;
        tick(); tick(); tick();
        ifb.data_gnt_i = 1'b1;
        tick(); ifb.data_gnt_i = 1'b0;
        checks++;
        if ({ifb.data_req_o, ifb.lsu_busy_o, ifb.lsu_done_o} !== 3'b010) begin
            failures++; $display("FAIL limit_gnt_wins got=%b exp=010", {ifb.data_req_o, ifb.lsu_busy_o, ifb.lsu_done_o});
        end
        ifb.data_rvalid_i = 1'b1; ifb.data_rdata_i = 32'hCAFE_F00D;
        tick(); ifb.data_rvalid_i = 1'b0;
        e = sbq.pop_front();
        checks++;
        if ({ifb.lsu_done_o, ifb.lsu_err_misaligned_o, ifb.lsu_err_timeout_o, ifb.lsu_rdata_o} !==
            {1'b1, e.mis, e.to, e.rdata}) begin
            failures++;
            $display("FAIL limit_result got=%h exp=%h",
                {ifb.lsu_done_o, ifb.lsu_err_misaligned_o, ifb.lsu_err_timeout_o, ifb.lsu_rdata_o},
                {1'b1, e.mis, e.to, e.rdata});
        end
        last_rdata_b = e.rdata;
        tick();
    endtask

    task automatic test_reset_mid();
        exp_t e;
        issue_a(1'b0, MEM_WORD, 1'b0, 32'h0000_6000, 32'd0);
        tick(); ifa.lsu_req_i = 1'b0;
        ifa.data_gnt_i = 1'b1;
        tick(); ifa.data_gnt_i = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if ({ifa.lsu_busy_o, ifa.lsu_done_o, ifa.data_req_o, ifa.data_be_o, ifa.data_addr_o, ifa.lsu_rdata_o} !== '0) begin
            failures++;
            $display("FAIL reset_mid got=%h exp=0",
                {ifa.lsu_busy_o, ifa.lsu_done_o, ifa.data_req_o, ifa.data_be_o, ifa.data_addr_o, ifa.lsu_rdata_o});
        end
        #2 rst_ni = 1'b1;
        last_rdata_a = 32'd0; last_rdata_b = 32'd0;
        tick();
        ifa.data_rvalid_i = 1'b1; ifa.data_rdata_i = 32'h5555_AAAA;
        tick(); ifa.data_rvalid_i = 1'b0;
        checks++;
        if ({ifa.lsu_done_o, ifa.lsu_rdata_o} !== {1'b0, 32'd0}) begin
            failures++; $display("FAIL reset_no_pending got=%h exp=0", {ifa.lsu_done_o, ifa.lsu_rdata_o});
        end
        issue_a(1'b0, MEM_WORD, 1'b0, 32'h0000_6004, 32'd0);
        sbq.push_back({1'b0, 1'b0, 32'd0, 32'h1122_3344});
        tick(); ifa.lsu_req_i = 1'b0;
        ifa.data_gnt_i = 1'b1;
        tick(); ifa.data_gnt_i = 1'b0;
        ifa.data_rvalid_i = 1'b1; ifa.data_rdata_i = 32'h1122_3344;
        tick(); ifa.data_rvalid_i = 1'b0;
        e = sbq.pop_front();
        checks++;
        if ({ifa.lsu_done_o, ifa.lsu_rdata_o} !== {1'b1, e.rdata}) begin
            failures++; $display("FAIL reset_then_load got=%h exp=%h", {ifa.lsu_done_o, ifa.lsu_rdata_o}, {1'b1, e.rdata});
        end
        last_rdata_a = e.rdata;
        tick();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        issue_a(1'b0, MEM_BYTE, 1'b0, 32'h0000_7001, 32'd0);
        sbq.push_back({1'b0, 1'b0, 32'd0, 32'h0000_00AB});
        tick(); ifa.lsu_req_i = 1'b0;
        ifa.data_gnt_i = 1'b1;
        tick(); ifa.data_gnt_i = 1'b0;
        ifa.data_rvalid_i = 1'b1; ifa.data_rdata_i = 32'h0000_AB00;
        tick(); ifa.data_rvalid_i = 1'b0;
        e = sbq.pop_front();
        checks++;
        if ({ifa.lsu_done_o, ifa.lsu_rdata_o} !== {1'b1, e.rdata}) begin
            failures++; $display("FAIL b2b_first got=%h exp=%h", {ifa.lsu_done_o, ifa.lsu_rdata_o}, {1'b1, e.rdata});
        end
        issue_a(1'b0, MEM_HALF, 1'b1, 32'h0000_7002, 32'd0);
        sbq.push_back({1'b0, 1'b0, 32'd0, 32'hFFFF_8001});
        tick(); ifa.lsu_req_i = 1'b0;
        checks++;
        if ({ifa.data_req_o, ifa.data_addr_o, ifa.data_be_o} !== {1'b1, 32'h0000_7000, 4'hF}) begin
            failures++;
            $display("FAIL b2b_req_next got=%h exp=%h", {ifa.data_req_o, ifa.data_addr_o, ifa.data_be_o},
                     {1'b1, 32'h0000_7000, 4'hF});
        end
        ifa.data_gnt_i = 1'b1;
        tick(); ifa.data_gnt_i = 1'b0;
        ifa.data_rvalid_i = 1'b1; ifa.data_rdata_i = 32'h8001_0000;
        tick(); ifa.data_rvalid_i = 1'b0;
        e = sbq.pop_front();
        checks++;
        if ({ifa.lsu_done_o, ifa.lsu_rdata_o} !== {1'b1, e.rdata}) begin
            failures++; $display("FAIL b2b_second got=%h exp=%h", {ifa.lsu_done_o, ifa.lsu_rdata_o}, {1'b1, e.rdata});
        end
        last_rdata_a = e.rdata;
        tick();
    endtask

    initial begin
        rst_ni = 1'b1;
        clear_inputs();
        #1 rst_ni = 1'b0;
        #1;
        test_reset();
        #10 rst_ni = 1'b1;
        tick();
        test_lb_signed();
        test_sh_delayed_gnt();
        test_misaligned();
        test_timeout();
        test_gnt_at_limit();
        test_reset_mid();
        test_back_to_back();
        checks++;
        if (sbq.size() != 0) begin
            failures++; $display("FAIL scoreboard_drain got=%0d exp=0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
